uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FIFO for a UART. It buffers received bytes and
// break markers as 9-bit entries {brk, data} and presents them to the consumer
// in first-word-fall-through form: the head entry is visible on out_data and
// out_break whenever out_valid is high.
//
// Parameters
//   DEPTH        number of entries (power of two, 4..256)
//   THRESH       fill level at which irq_level asserts (1..DEPTH)
// Ports
//   clk          system clock; all logic is on its rising edge
//   resetn       synchronous active-low reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe: rx_data holds a new byte
//   rx_break     one-cycle strobe: a break condition was detected
//   flush        discard all contents at the next edge
//   out_data     head-of-queue byte
//   out_break    head-of-queue break marker
//   out_valid    head entry is valid (FIFO not empty)
//   out_ready    consumer accepts the head when high
//   count        number of stored entries (0..DEPTH)
//   full, empty  count==DEPTH, count==0
//   overflow     sticky: an entry was dropped because the FIFO was full
//   clr_overflow clears overflow
//   irq_level    count >= THRESH
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_break,
    input  logic                       flush,
    output logic [7:0]                 out_data,
    output logic                       out_break,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic                       irq_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             push_req;
    logic             do_push;
    logic             do_pop;
    logic             ovf_event;
    logic [8:0]       wr_entry;
    logic [8:0]       head;

    // Status flags come straight from the registered count.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign irq_level = (count_q >= CNT_W'(THRESH));
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Fall-through read: the head is an asynchronous read at the read pointer,
    // so a freshly written entry is visible the cycle after its push.
    assign head      = mem[rd_ptr_q];
    assign out_data  = head[7:0];
    assign out_break = head[8];

    // A break outranks a coincident byte and is stored as {1, 8'h00}.
    assign push_req  = rx_valid | rx_break;
    assign wr_entry  = rx_break ? 9'h100 : {1'b0, rx_data};

    always_comb begin
        do_pop     = out_valid & out_ready & !flush;
        // While full, a push is only accepted if a pop frees the slot this cycle.
        do_push    = push_req & !flush & (!full | (out_valid & out_ready));
        ovf_event  = push_req & !flush & full & !(out_valid & out_ready);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A new drop outranks a same-cycle clear so the event is never lost.
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (resetn && do_push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (DEPTH=16, THRESH=8).
// A queue-based reference model tracks what the FIFO must hold; a compare
// process checks every DUT output against it on each falling edge, and the
// directed sequence adds hand-computed literal expectations.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_break = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] out_data;
    logic       out_break;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic       irq_level;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Reference model state.
    logic [8:0] mq[$];
    bit         m_ovf = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_break     (rx_break),
        .flush        (flush),
        .out_data     (out_data),
        .out_break    (out_break),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .irq_level    (irq_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue semantics evaluated on each rising edge
    // from the inputs that were stable before the edge.
    always @(posedge clk) begin
        bit pop, push, evt;
        logic [8:0] e;
        if (!resetn) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            mq.delete();
            if (clr_overflow) m_ovf = 1'b0;
            $display("txn flush");
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            push = rx_valid || rx_break;
            evt  = push && (mq.size() == DEPTH) && !pop;
            if (pop) begin
                e = mq.pop_front();
                $display("txn pop  brk=%0d data=0x%02h", e[8], e[7:0]);
            end
            if (push && !evt) begin
                e = rx_break ? 9'h100 : {1'b0, rx_data};
                mq.push_back(e);
                $display("txn push brk=%0d data=0x%02h", e[8], e[7:0]);
            end
            if (evt) begin
                m_ovf = 1'b1;
                $display("txn drop (full)");
            end else if (clr_overflow) begin
                m_ovf = 1'b0;
            end
        end
    end

    // Compare process: every output against the model, away from the edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_count",     32'(count),     32'(mq.size()));
            check("cmp_empty",     32'(empty),     32'(mq.size() == 0));
            check("cmp_full",      32'(full),      32'(mq.size() == DEPTH));
            check("cmp_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("cmp_irq_level", 32'(irq_level), 32'(mq.size() >= THRESH));
            check("cmp_overflow",  32'(overflow),  32'(m_ovf));
            if (mq.size() != 0) begin
                check("cmp_out_data",  32'(out_data),  32'(mq[0][7:0]));
                check("cmp_out_break", 32'(out_break), 32'(mq[0][8]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle state.
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        cmp_en = 1'b1;
        check("rst_count",     32'(count),     32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_irq",       32'(irq_level), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);

        // out_ready while empty changes nothing.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);

        // Three bytes, then drain on successive cycles.
        push(8'h41);
        check("latency_valid", 32'(out_valid), 32'd1);
        push(8'h42);
        push(8'h43);
        check("three_count", 32'(count),    32'd3);
        check("three_head",  32'(out_data), 32'h41);
        out_ready = 1'b1;
        check("drain0", 32'(out_data), 32'h41);
        tick();
        check("drain1", 32'(out_data), 32'h42);
        tick();
        check("drain2", 32'(out_data), 32'h43);
        tick();
        out_ready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);

        // Break outranks a coincident byte.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        rx_break = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_break = 1'b0;
        check("brk_count", 32'(count),     32'd1);
        check("brk_flag",  32'(out_break), 32'd1);
        check("brk_data",  32'(out_data),  32'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("brk_popped", 32'(empty), 32'd1);

        // Fill to DEPTH, then one more push overflows.
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        check("fill_full",     32'(full),     32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        push(8'hEE);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd16);
        check("ovf_head",  32'(out_data), 32'h10);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Push and pop together while full: count stays, no overflow.
        rx_valid  = 1'b1;
        rx_data   = 8'hAA;
        out_ready = 1'b1;
        tick();
        rx_valid  = 1'b0;
        check("pp_count", 32'(count),    32'd16);
        check("pp_full",  32'(full),     32'd1);
        check("pp_ovf",   32'(overflow), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            check("readback", 32'(out_data), 32'(8'h10 + i));
            tick();
        end
        check("readback_last", 32'(out_data), 32'hAA);
        tick();
        out_ready = 1'b0;
        check("readback_empty", 32'(empty), 32'd1);

        // Threshold interrupt.
        for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
        check("irq_at7", 32'(irq_level), 32'd0);
        push(8'h67);
        check("irq_at8", 32'(irq_level), 32'd1);
        out_ready = 1'b1;
        tick();
        check("irq_pop1", 32'(irq_level), 32'd0);
        tick();
        tick();
        out_ready = 1'b0;
        check("pre_flush_count", 32'(count), 32'd5);

        // Flush outranks a same-cycle push.
        flush    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tick();
        flush    = 1'b0;
        rx_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);

        // Mid-operation reset discards entries.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("pre_rst_count", 32'(count), 32'd3);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_rst_count", 32'(count),     32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);

        // Entries after reset flow normally again.
        push(8'h5A);
        check("post_rst_data", 32'(out_data), 32'h5A);
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
